// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: Register FunSel codes and FSM states.
package fetch_pkg;

   localparam logic [2:0] FS_DEC   = 3'b000;
   localparam logic [2:0] FS_INC   = 3'b001;
   localparam logic [2:0] FS_LOAD  = 3'b010;
   localparam logic [2:0] FS_CLR   = 3'b011;
   localparam logic [2:0] FS_CLRWL = 3'b100;
   localparam logic [2:0] FS_WL    = 3'b101;
   localparam logic [2:0] FS_WH    = 3'b110;
   localparam logic [2:0] FS_SEXT  = 3'b111;

   typedef enum logic [2:0] {
      S_CLR = 3'd0,
      S_B0  = 3'd1,
      S_B1  = 3'd2,
      S_VAL = 3'd3,
      S_ERR = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive cycles spent waiting for a memory byte and flags the timeout cycle.
module fetch_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic Clock,
   input  logic Reset,
   input  logic wait_s,
   output logic timeout_s
);
   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic [CW-1:0] wait_cnt_r;

   // Wait counter: runs while a byte is outstanding, clears otherwise.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wait_cnt_r <= '0;
      end else if (wait_s) begin
         wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
         wait_cnt_r <= '0;
      end
   end

   // With MAX_WAIT of zero the counter just wraps and never times out.
   assign timeout_s = (MAX_WAIT != 0) && wait_s && (wait_cnt_r == CW'(MAX_WAIT));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM driving the PC and IR Register blocks, two bytes per instruction.
// Define FETCH_INSTR_COUNT_EN to add the InstrCount output.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int LOW_FIRST = 1,
   parameter int MAX_WAIT  = 15
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        MemRdy,
   output logic        MemRead,
   input  logic        InstrReady,
   output logic        InstrValid,
   input  logic        BranchEn,
   output logic        PC_E,
   output logic [2:0]  PC_FunSel,
   output logic        IR_E,
   output logic [2:0]  IR_FunSel,
   output logic        FetchErr
`ifdef FETCH_INSTR_COUNT_EN
   ,
   output logic [15:0] InstrCount
`endif
);
   localparam logic [2:0] FS_FIRST  = (LOW_FIRST != 0) ? FS_CLRWL : FS_WH;
   localparam logic [2:0] FS_SECOND = (LOW_FIRST != 0) ? FS_WH : FS_WL;

   fetch_state_e state_r;
   fetch_state_e state_nxt_s;
   logic         wait_s;
   logic         timeout_s;

   assign wait_s = !Reset && !MemRdy && ((state_r == S_B0) || (state_r == S_B1));

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .Clock     (Clock),
      .Reset     (Reset),
      .wait_s    (wait_s),
      .timeout_s (timeout_s)
   );

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= S_CLR;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and register commands; all outputs stay low while Reset is high.
   always_comb begin
      state_nxt_s = state_r;
      MemRead     = 1'b0;
      InstrValid  = 1'b0;
      PC_E        = 1'b0;
      PC_FunSel   = FS_DEC;
      IR_E        = 1'b0;
      IR_FunSel   = FS_DEC;
      FetchErr    = 1'b0;
      if (Reset) begin
         state_nxt_s = S_CLR;
      end else begin
         case (state_r)
            S_CLR: begin
               PC_E        = 1'b1;
               PC_FunSel   = FS_CLR;
               IR_E        = 1'b1;
               IR_FunSel   = FS_CLR;
               state_nxt_s = S_B0;
            end
            S_B0: begin
               MemRead = 1'b1;
               if (MemRdy) begin
                  PC_E        = 1'b1;
                  PC_FunSel   = FS_INC;
                  IR_E        = 1'b1;
                  IR_FunSel   = FS_FIRST;
                  state_nxt_s = S_B1;
               end else if (timeout_s) begin
                  state_nxt_s = S_ERR;
               end else begin
                  state_nxt_s = S_B0;
               end
            end
            S_B1: begin
               MemRead = 1'b1;
               if (MemRdy) begin
                  PC_E        = 1'b1;
                  PC_FunSel   = FS_INC;
                  IR_E        = 1'b1;
                  IR_FunSel   = FS_SECOND;
                  state_nxt_s = S_VAL;
               end else if (timeout_s) begin
                  state_nxt_s = S_ERR;
               end else begin
                  state_nxt_s = S_B1;
               end
            end
            S_VAL: begin
               // IR is never enabled here, so the instruction is stable while offered.
               InstrValid = 1'b1;
               if (InstrReady) begin
                  if (BranchEn) begin
                     PC_E      = 1'b1;
                     PC_FunSel = FS_LOAD;
                  end else begin
                     PC_E      = 1'b0;
                  end
                  state_nxt_s = S_B0;
               end else begin
                  state_nxt_s = S_VAL;
               end
            end
            S_ERR: begin
               FetchErr    = 1'b1;
               state_nxt_s = S_ERR;
            end
            default: begin
               state_nxt_s = S_CLR;
            end
         endcase
      end
   end

`ifdef FETCH_INSTR_COUNT_EN
   logic [15:0] instr_count_r;

   // Accepted-instruction counter, wraps at 16'hFFFF.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         instr_count_r <= 16'h0000;
      end else if (InstrValid && InstrReady) begin
         instr_count_r <= instr_count_r + 16'h0001;
      end else begin
         instr_count_r <= instr_count_r;
      end
   end

   assign InstrCount = instr_count_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (default, LOW_FIRST=0, MAX_WAIT=3) driving
// behavioural PC/IR Register models over a byte memory.
module tb_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        MemRdy;
   logic        InstrReady;
   logic        BranchEn;
   logic [15:0] pc_target;

   logic        mem_read    [3];
   logic        instr_valid [3];
   logic        pc_e        [3];
   logic        ir_e        [3];
   logic        fetch_err   [3];
   logic [2:0]  pc_fs       [3];
   logic [2:0]  ir_fs       [3];
   logic [15:0] pc [3] = '{16'hDEAD, 16'hDEAD, 16'hDEAD};
   logic [15:0] ir [3] = '{16'hBEEF, 16'hBEEF, 16'hBEEF};
`ifdef FETCH_INSTR_COUNT_EN
   logic [15:0] icount [3];
`endif

   logic [7:0] mem [0:65535];
   int tests_run    = 0;
   int tests_failed = 0;

   always #5 Clock = ~Clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fetch_sequencer #(
         .LOW_FIRST ((g == 1) ? 0 : 1),
         .MAX_WAIT  ((g == 2) ? 3 : 15)
      ) u_dut (
         .Clock      (Clock),
         .Reset      (Reset),
         .MemRdy     (MemRdy),
         .MemRead    (mem_read[g]),
         .InstrReady (InstrReady),
         .InstrValid (instr_valid[g]),
         .BranchEn   (BranchEn),
         .PC_E       (pc_e[g]),
         .PC_FunSel  (pc_fs[g]),
         .IR_E       (ir_e[g]),
         .IR_FunSel  (ir_fs[g]),
         .FetchErr   (fetch_err[g])
`ifdef FETCH_INSTR_COUNT_EN
         ,
         .InstrCount (icount[g])
`endif
      );
   end

   // Instance 1 sees the memory with byte pairs swapped, so it reads 12h,34h where others read 34h,12h.
   function automatic logic [7:0] mem_rd(input logic [15:0] addr, input int k);
      return (k == 1) ? mem[addr ^ 16'h0001] : mem[addr];
   endfunction

   function automatic logic [15:0] reg_next(input logic [15:0] q, input logic [2:0] fs,
                                             input logic [15:0] d, input logic [7:0] i);
      case (fs)
         3'b000:  return q - 16'd1;
         3'b001:  return q + 16'd1;
         3'b010:  return d;
         3'b011:  return 16'h0000;
         3'b100:  return {8'h00, i};
         3'b101:  return {q[15:8], i};
         3'b110:  return {i, q[7:0]};
         default: return {{8{i[7]}}, i};
      endcase
   endfunction

   // Behavioural PC and IR Register blocks.
   always @(posedge Clock) begin
      for (int k = 0; k < 3; k++) begin
         if (pc_e[k]) pc[k] <= reg_next(pc[k], pc_fs[k], pc_target, 8'h00);
         if (ir_e[k]) ir[k] <= reg_next(ir[k], ir_fs[k], 16'h0000, mem_rd(pc[k], k));
      end
   end

   function automatic logic [10:0] obs(input int k);
      return {fetch_err[k], instr_valid[k], mem_read[k], pc_e[k], pc_fs[k], ir_e[k], ir_fs[k]};
   endfunction

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset;
      Reset = 1'b1; MemRdy = 1'b0; InstrReady = 1'b0; BranchEn = 1'b0; pc_target = 16'h0000;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1; MemRdy = 1'b1; InstrReady = 1'b1; BranchEn = 1'b1; pc_target = 16'h1111;
      tick();
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (obs(k) !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs[%0d]: got %b, expected 0", k, obs(k));
         end
      end
      tick();
      Reset = 1'b0; MemRdy = 1'b0; InstrReady = 1'b0; BranchEn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (obs(k) !== 11'b000_1011_1011) begin
            tests_failed++;
            $display("FAIL clr_state_outputs[%0d]: got %b, expected 00010111011", k, obs(k));
         end
      end
   endtask

   task automatic test_basic;
      do_reset();
      MemRdy = 1'b1; InstrReady = 1'b1;
      mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;
      for (int c = 1; c <= 6; c++) begin
         tick();
         tests_run++;
         if (instr_valid[0] !== ((c == 3) || (c == 6))) begin
            tests_failed++;
            $display("FAIL basic_valid cycle %0d: got %b", c, instr_valid[0]);
         end
         if (c == 1) begin
            tests_run++;
            if ({mem_read[0], pc[0]} !== {1'b1, 16'h0000}) begin
               tests_failed++;
               $display("FAIL basic_first_read: got rd=%b pc=%h, expected rd=1 pc=0000", mem_read[0], pc[0]);
            end
         end
         if ((c == 3) || (c == 6)) begin
            tests_run++;
            if ({ir[0], pc[0]} !== ((c == 3) ? {16'h1234, 16'h0002} : {16'h5678, 16'h0004})) begin
               tests_failed++;
               $display("FAIL basic_instr cycle %0d: got ir=%h pc=%h", c, ir[0], pc[0]);
            end
         end
      end
   endtask

   task automatic test_low_first;
      do_reset();
      MemRdy = 1'b1; InstrReady = 1'b1;
      mem[0] = 8'h34; mem[1] = 8'h12;
      tick();
      tick();
      tests_run++;
      if ({ir[1][15:8], ir_e[1], ir_fs[1], ir_fs[0]} !== {8'h12, 1'b1, 3'b101, 3'b110}) begin
         tests_failed++;
         $display("FAIL low_first_b1: got irh=%h e=%b fs1=%b fs0=%b, expected 12 1 101 110",
                  ir[1][15:8], ir_e[1], ir_fs[1], ir_fs[0]);
      end
      tick();
      tests_run++;
      if ({instr_valid[1], ir[1]} !== {1'b1, 16'h1234}) begin
         tests_failed++;
         $display("FAIL low_first_instr: got v=%b ir=%h, expected 1 1234", instr_valid[1], ir[1]);
      end
   endtask

   task automatic test_hold;
      logic [15:0] ir_hold;
      logic [15:0] pc_hold;
      do_reset();
      MemRdy = 1'b1; InstrReady = 1'b0;
      tick(); tick(); tick();
      ir_hold = ir[0];
      pc_hold = pc[0];
      for (int c = 0; c < 5; c++) begin
         MemRdy = 1'($urandom_range(1, 0));
         tick();
         tests_run++;
         if ({instr_valid[0], mem_read[0], ir_e[0], ir[0], pc[0]} !== {3'b100, ir_hold, pc_hold}) begin
            tests_failed++;
            $display("FAIL hold cycle %0d: got v=%b rd=%b ire=%b ir=%h pc=%h, expected 1 0 0 %h %h",
                     c, instr_valid[0], mem_read[0], ir_e[0], ir[0], pc[0], ir_hold, pc_hold);
         end
      end
   endtask

   // Continues from the S_VAL state left by test_hold.
   task automatic test_branch;
      pc_target = 16'h0100; InstrReady = 1'b1; BranchEn = 1'b1; MemRdy = 1'b1;
      mem[16'h0100] = 8'hCD; mem[16'h0101] = 8'hAB;
      #1;
      tests_run++;
      if ({instr_valid[0], mem_read[0], pc_e[0], pc_fs[0], ir_e[0]} !== 7'b1_0_1_010_0) begin
         tests_failed++;
         $display("FAIL branch_cmd: got %b, expected 1010100",
                  {instr_valid[0], mem_read[0], pc_e[0], pc_fs[0], ir_e[0]});
      end
      tick();
      BranchEn = 1'b1; pc_target = 16'h5555;
      tests_run++;
      if ({mem_read[0], pc[0]} !== {1'b1, 16'h0100}) begin
         tests_failed++;
         $display("FAIL branch_pc: got rd=%b pc=%h, expected 1 0100", mem_read[0], pc[0]);
      end
      InstrReady = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({instr_valid[0], ir[0], pc[0]} !== {1'b1, 16'hABCD, 16'h0102}) begin
         tests_failed++;
         $display("FAIL branch_fetch: got v=%b ir=%h pc=%h, expected 1 ABCD 0102", instr_valid[0], ir[0], pc[0]);
      end
   endtask

   task automatic test_timeout;
      do_reset();
      #1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         tests_run++;
         if ({fetch_err[2], fetch_err[0]} !== {(e == 5), 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_edge %0d: got err2=%b err0=%b, expected %b 0", e, fetch_err[2], fetch_err[0], e == 5);
         end
      end
      MemRdy = 1'b1; InstrReady = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests_run++;
         if ({fetch_err[2], mem_read[2], pc_e[2], ir_e[2], instr_valid[2]} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL err_sticky cycle %0d: got %b, expected 10000", c,
                     {fetch_err[2], mem_read[2], pc_e[2], ir_e[2], instr_valid[2]});
         end
      end
      Reset = 1'b1;
      #1;
      tests_run++;
      if (obs(2) !== 11'd0) begin
         tests_failed++;
         $display("FAIL err_reset_outputs: got %b, expected 0", obs(2));
      end
      tick();
      Reset = 1'b0;
      #1;
      tests_run++;
      if (obs(2) !== 11'b000_1011_1011) begin
         tests_failed++;
         $display("FAIL err_exit_clr: got %b, expected 00010111011", obs(2));
      end
      tick();
      tests_run++;
      if ({pc[2], fetch_err[2], mem_read[2]} !== {16'h0000, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL err_refetch: got pc=%h err=%b rd=%b, expected 0000 0 1", pc[2], fetch_err[2], mem_read[2]);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] pc_hold;
      do_reset();
      MemRdy = 1'b1; InstrReady = 1'b1; BranchEn = 1'b1;
      tick();
      tick();
      pc_hold = pc[0];
      Reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (obs(k) !== 11'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs[%0d]: got %b, expected 0", k, obs(k));
         end
      end
      tick();
      tests_run++;
      if ({obs(0), pc[0]} !== {11'd0, pc_hold}) begin
         tests_failed++;
         $display("FAIL mid_reset_hold: got %b pc=%h, expected 0 pc=%h", obs(0), pc[0], pc_hold);
      end
      Reset = 1'b0;
      #1;
      tests_run++;
      if (obs(0) !== 11'b000_1011_1011) begin
         tests_failed++;
         $display("FAIL mid_reset_clr: got %b, expected 00010111011", obs(0));
      end
`ifdef FETCH_INSTR_COUNT_EN
      tests_run++;
      if (icount[0] !== 16'h0000) begin
         tests_failed++;
         $display("FAIL instr_count_reset: got %h, expected 0000", icount[0]);
      end
`endif
      tick();
      tests_run++;
      if ({pc[0], ir[0], mem_read[0]} !== {16'h0000, 16'h0000, 1'b1}) begin
         tests_failed++;
         $display("FAIL mid_reset_fresh: got pc=%h ir=%h rd=%b, expected 0000 0000 1", pc[0], ir[0], mem_read[0]);
      end
   endtask

   task automatic test_random;
      logic [15:0] exp_pc;
      int          bytes;
      int          zrun;
      int          handshakes;
      do_reset();
      exp_pc = 16'h0000; bytes = 0; zrun = 0; handshakes = 0;
      for (int n = 0; n < 600; n++) begin
         MemRdy     = (zrun >= 3) ? 1'b1 : ($urandom_range(3, 0) != 0);
         zrun       = MemRdy ? 0 : zrun + 1;
         InstrReady = 1'($urandom_range(1, 0));
         BranchEn   = ($urandom_range(3, 0) == 0);
         pc_target  = 16'($urandom());
         #1;
         if (mem_read[0] && MemRdy) bytes++;
         tests_run++;
         if (ir_e[0] && instr_valid[0]) begin
            tests_failed++;
            $display("FAIL rand_ir_stable cycle %0d: IR enabled while valid", n);
         end
         if (instr_valid[0] && InstrReady) begin
            tests_run++;
            if ({ir[0], ir[1], pc[0], 8'(bytes)} !==
                {mem[exp_pc + 16'd1], mem[exp_pc], mem[exp_pc ^ 16'h0001], mem[(exp_pc + 16'd1) ^ 16'h0001],
                 exp_pc + 16'd2, 8'd2}) begin
               tests_failed++;
               $display("FAIL rand_instr cycle %0d: got ir0=%h ir1=%h pc=%h bytes=%0d for fetch at %h",
                        n, ir[0], ir[1], pc[0], bytes, exp_pc);
            end
`ifdef FETCH_INSTR_COUNT_EN
            tests_run++;
            if (icount[0] !== 16'(handshakes)) begin
               tests_failed++;
               $display("FAIL rand_instr_count: got %h, expected %h", icount[0], 16'(handshakes));
            end
`endif
            exp_pc = BranchEn ? pc_target : exp_pc + 16'd2;
            bytes  = 0;
            handshakes++;
         end
         tick();
      end
      tests_run++;
      if ({handshakes > 40, fetch_err[0], fetch_err[1], fetch_err[2]} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL rand_progress: got %0d handshakes, err=%b%b%b", handshakes,
                  fetch_err[0], fetch_err[1], fetch_err[2]);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom());
      test_reset();
      test_basic();
      test_low_first();
      test_hold();
      test_branch();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
